// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline encodings for the EX/MEM boundary.
// Holds RV32I load/store funct3 codes and data_memory size codes.
package ex_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  function automatic logic f3_illegal(
    input logic [2:0] f3
  );
    return (f3 == 3'b011) || (f3 == 3'b110) ||
           (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Request bus from the EX/MEM register to data_memory.
// The stage drives it (master); data_memory samples it (slave).
interface ex_mem_stage_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_size;
  logic                  unsigned_op;
  logic [1:0]            byte_offset;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output mem_read, mem_write, mem_size,
    output unsigned_op, byte_offset,
    output address, write_data
  );

  modport slave (
    input mem_read, mem_write, mem_size,
    input unsigned_op, byte_offset,
    input address, write_data
  );
endinterface

// File: rtl/mem_align_check.sv
// Combinational fault and alignment decode for one load/store.
// With MISALIGN_TRAP_EN undefined, offsets are forced aligned.
module mem_align_check
  import ex_mem_stage_pkg::*;
(
  input  logic       i_access,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_offset,
  output logic       o_fault,
  output logic [1:0] o_size,
  output logic [1:0] o_offset
);

  logic       w_illegal;
  logic       w_misal;
  logic [1:0] w_size;

  always_comb begin
    w_illegal = f3_illegal(i_funct3);
    w_size    = i_funct3[1:0];
    w_misal   = ((w_size == SZ_HALF) && i_offset[0]) ||
                ((w_size == SZ_WORD) && (i_offset != 2'b00));
    o_fault   = i_access & (w_illegal | w_misal);
`ifdef MISALIGN_TRAP_EN
    o_size    = w_size;
    o_offset  = i_offset;
`else
    o_size    = w_illegal ? SZ_WORD : w_size;
    o_offset  = i_offset;
    unique case (1'b1)
      (o_size == SZ_HALF): o_offset = {i_offset[1], 1'b0};
      (o_size == SZ_WORD): o_offset = 2'b00;
      default:             o_offset = i_offset;
    endcase
`endif
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data_memory request decode.
// Optional macro MISALIGN_TRAP_EN turns faults into suppressed traps.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic [2:0]            i_funct3,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  input  logic [4:0]            i_rd,
  input  logic                  i_err_clear,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [1:0]            o_mem_size,
  output logic                  o_unsigned_op,
  output logic [1:0]            o_byte_offset,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_write_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [4:0]            o_rd,
  output logic                  o_reg_write,
  output logic                  o_mem_to_reg,
  output logic                  o_misaligned,
  output logic [15:0]           o_access_count
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       w_access;
  logic       w_fault;
  logic       w_sup;
  logic       w_bubble;
  logic [1:0] w_size;
  logic [1:0] w_offset;

  assign w_access = i_valid & (i_mem_read | i_mem_write);
  assign w_sup    = TrapEn & w_fault;
  assign w_bubble = i_flush | (~i_stall & ~i_valid);

  mem_align_check u_align (
    .i_access (w_access),
    .i_funct3 (i_funct3),
    .i_offset (i_alu_result[1:0]),
    .o_fault  (w_fault),
    .o_size   (w_size),
    .o_offset (w_offset)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid        <= 1'b0;
      o_mem_read     <= 1'b0;
      o_mem_write    <= 1'b0;
      o_reg_write    <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_mem_size     <= '0;
      o_unsigned_op  <= 1'b0;
      o_byte_offset  <= '0;
      o_address      <= '0;
      o_write_data   <= '0;
      o_alu_result   <= '0;
      o_rd           <= '0;
      o_misaligned   <= 1'b0;
      o_access_count <= '0;
    end else if (w_bubble) begin
      o_valid        <= 1'b0;
      o_mem_read     <= 1'b0;
      o_mem_write    <= 1'b0;
      o_reg_write    <= 1'b0;
      o_mem_to_reg   <= 1'b0;
      o_mem_size     <= '0;
      o_unsigned_op  <= 1'b0;
      o_byte_offset  <= '0;
      o_address      <= '0;
      o_write_data   <= '0;
      o_alu_result   <= '0;
      o_rd           <= '0;
      o_misaligned   <= o_misaligned & ~i_err_clear;
    end else if (!i_stall) begin
      o_valid        <= 1'b1;
      o_mem_read     <= i_mem_read & ~w_sup;
      o_mem_write    <= i_mem_write & ~w_sup;
      o_reg_write    <= i_reg_write & ~w_sup;
      o_mem_to_reg   <= i_mem_to_reg;
      o_mem_size     <= w_size;
      o_unsigned_op  <= i_funct3[2];
      o_byte_offset  <= w_offset;
      o_address      <= i_alu_result[ADDR_WIDTH+1:2];
      o_write_data   <= i_rs2_data;
      o_alu_result   <= i_alu_result;
      o_rd           <= i_rd;
      // a fault captured this cycle overrides a clear request
      o_misaligned   <= w_sup | (o_misaligned & ~i_err_clear);
      if (w_access && !w_sup && o_access_count != 16'hFFFF)
        o_access_count <= o_access_count + 16'd1;
    end
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, word-index width of the data_memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have inputs i_stall (1, hold register), i_flush (1, insert bubble), i_valid (1, EX instruction valid).
REQ-006 SHALL have inputs i_alu_result (DATA_WIDTH, byte address/ALU value), i_rs2_data (DATA_WIDTH, store data), i_funct3 (3, RV32I load/store funct3).
REQ-007 SHALL have inputs i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg (1 each) and i_rd (5).
REQ-008 SHALL have input i_err_clear (1), clears sticky fault flag.
REQ-009 SHALL have outputs to data_memory: o_mem_read (1), o_mem_write (1), o_mem_size (2), o_unsigned_op (1), o_byte_offset (2), o_address (ADDR_WIDTH), o_write_data (DATA_WIDTH).
REQ-010 SHALL have outputs to MEM/WB: o_valid (1), o_alu_result (DATA_WIDTH), o_rd (5), o_reg_write (1), o_mem_to_reg (1).
REQ-011 SHALL have outputs o_misaligned (1, sticky fault) and o_access_count (16, saturating access counter).

Function
REQ-012 SHALL register all outputs; latency exactly one cycle from EX inputs to outputs.
REQ-013 SHALL derive o_address = i_alu_result[ADDR_WIDTH+1:2], o_byte_offset = i_alu_result[1:0], o_mem_size = i_funct3[1:0], o_unsigned_op = i_funct3[2].
REQ-014 SHALL pass i_rs2_data unshifted to o_write_data; lane placement belongs to data_memory.
REQ-015 SHALL flag an access fault when a valid read/write has size 01 with offset[0]=1, size 10 with offset!=00, or funct3 in {011,110,111}.
REQ-016 SHALL, on i_stall=1 and i_flush=0, hold every output and the counter unchanged.
REQ-017 SHALL, on i_flush=1, load a bubble: o_valid, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg = 0; flush wins over stall.
REQ-018 SHALL, when i_valid=0 and not stalled, load a bubble as in REQ-017.
REQ-019 SHALL increment o_access_count by one on each capture of a valid, non-suppressed read or write; saturate at 16'hFFFF.
REQ-020 SHALL clear o_misaligned on i_err_clear=1; a new fault in the same cycle wins (flag stays 1).

Reset
REQ-021 SHALL, while i_reset=0, asynchronously force every output, the fault flag and the counter to 0.
REQ-022 SHALL, on reset release mid-operation, resume with a bubble; no partial access emitted.

Configuration
REQ-023 SHALL support macro MISALIGN_TRAP_EN.
REQ-024 SHALL, with MISALIGN_TRAP_EN defined, on fault capture with o_mem_read, o_mem_write, o_reg_write = 0, o_valid = 1, set o_misaligned, not count.
REQ-025 SHALL, without MISALIGN_TRAP_EN, force offset aligned (half: bit0=0; word: 00), treat illegal funct3 as word, perform and count access, tie o_misaligned to 0.

Structure
REQ-026 SHALL take funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and size codes (00 byte, 01 half, 10 word) from the shared pipeline package.
REQ-027 SHALL implement fault/alignment decode as combinational sub-module mem_align_check; register and counter in ex_mem_stage.

Verification
REQ-028 SHALL cover: SW, i_alu_result=32'h0000_0104, i_rs2_data=32'hDEAD_BEEF -> next cycle o_address=65, o_byte_offset=0, o_mem_size=10, o_mem_write=1, count=1.
REQ-029 SHALL cover: LHU at 32'h0000_0012 -> o_byte_offset=2, o_mem_size=01, o_unsigned_op=1, o_mem_read=1, no fault.
REQ-030 SHALL cover: LW at 32'h0000_0013 -> with MISALIGN_TRAP_EN o_mem_read=0, o_misaligned=1, count unchanged; without it o_byte_offset=0, o_mem_read=1.
REQ-031 SHALL cover: stall 3 cycles after SB at 32'h0000_0001 -> outputs constant 3 cycles; stall+flush together -> bubble next cycle.
REQ-032 SHALL cover: counter preloaded by 65535 accesses, one more SW -> o_access_count stays 16'hFFFF.
REQ-033 SHALL cover: i_reset=0 asserted between clock edges during valid LW -> all outputs 0 immediately, bubble after release.
